// File: rtl/sdram_cmd_sequencer_if.sv
// mcu-facing opcode/address bundle plus the SDRAM command pins driven by the sequencer.
interface sdram_cmd_sequencer_if #(
   parameter int ROW_W = 13,
   parameter int COL_W = 9,
   parameter int BA_W  = 2
);
   logic [2:0]       opcode;
   logic [ROW_W-1:0] row;
   logic [COL_W-1:0] col;
   logic [BA_W-1:0]  bank;
   logic             idle;
   logic             cke;
   logic             cs_n;
   logic             ras_n;
   logic             cas_n;
   logic             we_n;
   logic [BA_W-1:0]  ba;
   logic [ROW_W-1:0] a;
   logic             dqm;
   logic             wr_ready;
   logic             rd_valid;

   modport master (
      output opcode, row, col, bank,
      input  idle, cke, cs_n, ras_n, cas_n, we_n, ba, a, dqm, wr_ready, rd_valid
   );

   modport slave (
      input  opcode, row, col, bank,
      output idle, cke, cs_n, ras_n, cas_n, we_n, ba, a, dqm, wr_ready, rd_valid
   );
endinterface

// File: rtl/sdram_cmd_sequencer.sv
// Expands mcu opcodes into timed SDRAM commands; outputs are registered one cycle behind the FSM state.
// idle is the only backpressure (opcodes ignored while busy). Define SEQ_PROTOCOL_CHECK_EN for a sticky err output.
module sdram_cmd_sequencer #(
   parameter int T_INIT    = 16,
   parameter int T_RCD     = 2,
   parameter int T_RP      = 2,
   parameter int T_RFC     = 7,
   parameter int T_MRD     = 2,
   parameter int T_WR      = 2,
   parameter int T_XSR     = 8,
   parameter int CAS_LAT   = 2,
   parameter int BURST_LEN = 8,
   parameter int ROW_W     = 13,
   parameter int COL_W     = 9,
   parameter int BA_W      = 2
) (
   input  logic                 clk,
   input  logic                 n_rst,
   sdram_cmd_sequencer_if.slave bus
`ifdef SEQ_PROTOCOL_CHECK_EN
   ,
   output logic                 err
`endif
);
   localparam int CNT_W = 16;

   localparam logic [3:0] CMD_NOP = 4'b0111;
   localparam logic [3:0] CMD_ACT = 4'b0011;
   localparam logic [3:0] CMD_RD  = 4'b0101;
   localparam logic [3:0] CMD_WR  = 4'b0100;
   localparam logic [3:0] CMD_PRE = 4'b0010;
   localparam logic [3:0] CMD_REF = 4'b0001;
   localparam logic [3:0] CMD_LMR = 4'b0000;

   localparam logic [ROW_W-1:0] MODE_A =
      ROW_W'({3'(CAS_LAT), 1'b0, 3'($clog2(BURST_LEN))});

   typedef enum logic [3:0] {
      UNINIT, INIT_WAIT, INIT_PRE, INIT_REF1, INIT_REF2, INIT_LMR,
      IDLE, ACT, RW, DATA, PRE, REF, SREF, SR_EXIT, WAIT
   } state_t;

   state_t           state, state_n, ret, ret_n, wait_to;
   logic [CNT_W-1:0] cnt, cnt_n, wait_len, beats, data_len;
   logic             wait_go, beat, accept;
   logic [1:0]       op_q;
   logic [ROW_W-1:0] row_q, a_col;
   logic [COL_W-1:0] col_q;
   logic [BA_W-1:0]  bank_q;

   logic             idle_d, cke_d, dqm_d, wr_d, rd_d;
   logic [3:0]       cmd_d;
   logic [BA_W-1:0]  ba_d;
   logic [ROW_W-1:0] a_d;

   // op_q[1] selects write, op_q[0] selects a full burst
   assign accept   = (state == IDLE) && (bus.opcode != 3'd0);
   assign beats    = op_q[0] ? CNT_W'(BURST_LEN) : CNT_W'(1);
   assign data_len = op_q[1] ? (beats - CNT_W'(1) + CNT_W'(T_WR - 1))
                             : (CNT_W'(CAS_LAT - 1) + beats);

   always_comb begin
      a_col     = ROW_W'(col_q);
      a_col[10] = 1'b0;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state        <= UNINIT;
         ret          <= IDLE;
         cnt          <= '0;
         op_q         <= '0;
         row_q        <= '0;
         col_q        <= '0;
         bank_q       <= '0;
         bus.idle     <= 1'b0;
         bus.cke      <= 1'b0;
         {bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n} <= CMD_NOP;
         bus.ba       <= '0;
         bus.a        <= '0;
         bus.dqm      <= 1'b1;
         bus.wr_ready <= 1'b0;
         bus.rd_valid <= 1'b0;
      end else begin
         state <= state_n;
         ret   <= ret_n;
         cnt   <= cnt_n;
         if (accept) begin
            op_q   <= bus.opcode[1:0];
            row_q  <= bus.row;
            col_q  <= bus.col;
            bank_q <= bus.bank;
         end
         bus.idle     <= idle_d;
         bus.cke      <= cke_d;
         {bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n} <= cmd_d;
         bus.ba       <= ba_d;
         bus.a        <= a_d;
         bus.dqm      <= dqm_d;
         bus.wr_ready <= wr_d;
         bus.rd_valid <= rd_d;
      end
   end

   always_comb begin
      state_n  = state;
      ret_n    = ret;
      cnt_n    = cnt;
      wait_go  = 1'b0;
      wait_len = '0;
      wait_to  = IDLE;
      beat     = 1'b0;
      idle_d   = 1'b0;
      cke_d    = 1'b1;
      cmd_d    = CMD_NOP;
      ba_d     = '0;
      a_d      = '0;
      dqm_d    = 1'b1;
      wr_d     = 1'b0;
      rd_d     = 1'b0;
      unique case (state)
         UNINIT: begin
            cke_d = 1'b0;
            if (bus.opcode == 3'd1) begin
               state_n = INIT_WAIT;
               cnt_n   = CNT_W'(T_INIT - 1);
            end
         end
         INIT_WAIT: begin
            if (cnt == '0) state_n = INIT_PRE;
            else           cnt_n   = cnt - CNT_W'(1);
         end
         INIT_PRE: begin
            cmd_d     = CMD_PRE;
            a_d[10]   = 1'b1;
            wait_go   = 1'b1;
            wait_len  = CNT_W'(T_RP);
            wait_to   = INIT_REF1;
         end
         INIT_REF1: begin
            cmd_d    = CMD_REF;
            wait_go  = 1'b1;
            wait_len = CNT_W'(T_RFC);
            wait_to  = INIT_REF2;
         end
         INIT_REF2: begin
            cmd_d    = CMD_REF;
            wait_go  = 1'b1;
            wait_len = CNT_W'(T_RFC);
            wait_to  = INIT_LMR;
         end
         INIT_LMR: begin
            cmd_d    = CMD_LMR;
            a_d      = MODE_A;
            wait_go  = 1'b1;
            wait_len = CNT_W'(T_MRD);
            wait_to  = IDLE;
         end
         IDLE: begin
            idle_d = 1'b1;
            if (accept) begin
               unique case (bus.opcode)
                  3'd1: begin
                     state_n = INIT_WAIT;
                     cnt_n   = CNT_W'(T_INIT - 1);
                  end
                  3'd2: begin
                     state_n = SREF;
                     cnt_n   = CNT_W'(1);
                  end
                  3'd3:    state_n = REF;
                  default: state_n = ACT;
               endcase
            end
         end
         ACT: begin
            cmd_d    = CMD_ACT;
            ba_d     = bank_q;
            a_d      = row_q;
            wait_go  = 1'b1;
            wait_len = CNT_W'(T_RCD);
            wait_to  = RW;
         end
         RW: begin
            cmd_d = op_q[1] ? CMD_WR : CMD_RD;
            ba_d  = bank_q;
            a_d   = a_col;
            if (op_q[1]) begin
               wr_d  = 1'b1;
               dqm_d = 1'b0;
            end
            if (data_len == '0) begin
               state_n = PRE;
            end else begin
               state_n = DATA;
               cnt_n   = data_len - CNT_W'(1);
            end
         end
         // writes: beats first, then the write-recovery gap; reads: CAS gap first, then beats
         DATA: begin
            ba_d = bank_q;
            if (op_q[1]) begin
               beat = (cnt >= CNT_W'(T_WR - 1));
               wr_d = beat;
            end else begin
               beat = (cnt < beats);
               rd_d = beat;
            end
            dqm_d = ~beat;
            if (cnt == '0) state_n = PRE;
            else           cnt_n   = cnt - CNT_W'(1);
         end
         PRE: begin
            cmd_d    = CMD_PRE;
            ba_d     = bank_q;
            a_d[10]  = 1'b1;
            wait_go  = 1'b1;
            wait_len = CNT_W'(T_RP);
            wait_to  = IDLE;
         end
         REF: begin
            cmd_d    = CMD_REF;
            wait_go  = 1'b1;
            wait_len = CNT_W'(T_RFC);
            wait_to  = IDLE;
         end
         SREF: begin
            cke_d = 1'b0;
            if (cnt != '0) cmd_d = CMD_REF;
            cnt_n = '0;
            if (bus.opcode != 3'd2) begin
               state_n = SR_EXIT;
               cnt_n   = CNT_W'(T_XSR - 1);
            end
         end
         SR_EXIT: begin
            if (cnt == '0) state_n = IDLE;
            else           cnt_n   = cnt - CNT_W'(1);
         end
         WAIT: begin
            if (cnt == '0) state_n = ret;
            else           cnt_n   = cnt - CNT_W'(1);
         end
         default: state_n = UNINIT;
      endcase
      // one-cycle command states pad out to their timing parameter through WAIT
      if (wait_go) begin
         if (wait_len > CNT_W'(1)) begin
            state_n = WAIT;
            cnt_n   = wait_len - CNT_W'(2);
            ret_n   = wait_to;
         end else begin
            state_n = wait_to;
         end
      end
   end

`ifdef SEQ_PROTOCOL_CHECK_EN
   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         err <= 1'b0;
      end else if (((state == UNINIT) && (bus.opcode >= 3'd2)) ||
                   ((state == SREF) && (bus.opcode >= 3'd4))) begin
         err <= 1'b1;
      end
   end
`endif
endmodule

// File: tb/tb_sdram_cmd_sequencer.sv
// Scoreboard bench: each driven opcode pushes its per-cycle expected pin trace; a negedge monitor pops and compares.
module tb_sdram_cmd_sequencer;
   localparam int T_RCD = 2;
   localparam int T_RP  = 2;
   localparam int T_WR  = 2;
   localparam int CL    = 2;

   localparam logic [3:0] NOP = 4'b0111;
   localparam logic [3:0] ACT = 4'b0011;
   localparam logic [3:0] RD  = 4'b0101;
   localparam logic [3:0] WR  = 4'b0100;
   localparam logic [3:0] PRE = 4'b0010;
   localparam logic [3:0] REF = 4'b0001;
   localparam logic [3:0] LMR = 4'b0000;

   localparam logic [23:0] EXP_RST = {NOP, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 2'b00, 13'h0000};

   typedef struct {
      int         cyc;
      int         op;
      int         k;
      logic [8:0] ctl;
      logic [8:0] msk;
      logic       chk_a;
      logic [14:0] addr;
   } exp_t;

   logic tb_clk = 1'b0;
   logic n_rst;
   int   cyc    = 0;
   int   n_chk  = 0;
   int   n_err  = 0;
   exp_t sb[$];
   exp_t e_m;

   sdram_cmd_sequencer_if #(.ROW_W(13), .COL_W(9), .BA_W(2)) bus ();

`ifdef SEQ_PROTOCOL_CHECK_EN
   logic err;
`endif

   sdram_cmd_sequencer dut (
      .clk   (tb_clk),
      .n_rst (n_rst),
      .bus   (bus)
`ifdef SEQ_PROTOCOL_CHECK_EN
      ,
      .err   (err)
`endif
   );

   always #5 tb_clk = ~tb_clk;
   always @(posedge tb_clk) cyc <= cyc + 1;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      if (obs !== exp) begin
         n_err++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [8:0] obs_ctl();
      return {bus.cs_n, bus.ras_n, bus.cas_n, bus.we_n, bus.cke, bus.idle,
              bus.dqm, bus.wr_ready, bus.rd_valid};
   endfunction

   function automatic logic [23:0] obs_all();
      return {obs_ctl(), bus.ba, bus.a};
   endfunction

   always @(negedge tb_clk) begin
      if (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e_m = sb.pop_front();
         if (e_m.cyc != cyc) begin
            check($sformatf("op%0d_c%0d_late", e_m.op, e_m.k), 32'(cyc), 32'(e_m.cyc));
         end else begin
            check($sformatf("op%0d_c%0d_ctl", e_m.op, e_m.k),
                  32'(obs_ctl() & e_m.msk), 32'(e_m.ctl & e_m.msk));
            if (e_m.chk_a)
               check($sformatf("op%0d_c%0d_addr", e_m.op, e_m.k),
                     32'({bus.ba, bus.a}), 32'(e_m.addr));
         end
      end
   end

   // ops 0..7 are opcodes; 8/10 = opcode 4/5 ignored in UNINIT; 9 = self-refresh release
   task automatic plan(input int op, input logic [1:0] b, input logic [12:0] r,
                       input logic [8:0] c, input int n_lim, output int n);
      int base, beats, b0, b1, pre;
      base  = cyc;
      beats = (op == 5 || op == 7) ? 8 : 1;
      b0    = (op >= 6) ? 1 + T_RCD : 1 + T_RCD + CL;
      b1    = b0 + beats - 1;
      pre   = (op >= 6) ? b1 + T_WR : b1 + 1;
      case (op)
         0:       n = 3;
         1:       n = 35;
         2:       n = 50;
         3:       n = 8;
         9:       n = 9;
         8, 10:   n = n_lim;
         default: n = pre + T_RP;
      endcase
      if (n_lim > 0 && n_lim < n) n = n_lim;
      for (int k = (op == 9) ? 0 : 1; k <= n; k++) begin
         logic [3:0]  cmd;
         logic        cke, idl, dqm, wrr, rdv, ca;
         logic [8:0]  msk;
         logic [14:0] ad;
         cmd = NOP; cke = 1'b1; idl = 1'b0; dqm = 1'b1; wrr = 1'b0; rdv = 1'b0;
         msk = '1; ca = 1'b0; ad = '0;
         case (op)
            0: idl = 1'b1;
            1: begin
               if (k == 17) begin cmd = PRE; ca = 1'b1; ad = 15'h0400; end
               else if (k == 19 || k == 26) cmd = REF;
               else if (k == 33) begin cmd = LMR; ca = 1'b1; ad = 15'h0023; end
               idl = (k == 35);
            end
            2: begin
               cke = 1'b0;
               if (k == 1) cmd = REF;
               else        msk[8:5] = 4'b0000;
            end
            3: begin
               if (k == 1) cmd = REF;
               idl = (k == 8);
            end
            8, 10: cke = 1'b0;
            9: begin
               if (k == 0) begin cke = 1'b0; msk[8:5] = 4'b0000; end
               idl = (k == 9);
            end
            default: begin
               if (k == 1) begin cmd = ACT; ca = 1'b1; ad = {b, r}; end
               if (k == 1 + T_RCD) begin
                  cmd = (op >= 6) ? WR : RD;
                  ca  = 1'b1;
                  ad  = {b, 4'b0000, c};
               end
               if (k >= b0 && k <= b1) begin
                  if (op >= 6) wrr = 1'b1;
                  else         rdv = 1'b1;
                  dqm = 1'b0;
               end
               if (k == pre) cmd = PRE;
               idl = (k == pre + T_RP);
            end
         endcase
         sb.push_back('{base + 1 + k, op, k, {cmd, cke, idl, dqm, wrr, rdv}, msk, ca, ad});
      end
   endtask

   task automatic do_op(input int op, input logic [1:0] b, input logic [12:0] r,
                        input logic [8:0] c, input int n_lim);
      int n;
      case (op)
         8:       bus.opcode = 3'd4;
         9:       bus.opcode = 3'd0;
         10:      bus.opcode = 3'd5;
         default: bus.opcode = 3'(op);
      endcase
      bus.bank = b;
      bus.row  = r;
      bus.col  = c;
      plan(op, b, r, c, n_lim, n);
      @(negedge tb_clk);
      if (op != 2 && op != 8 && op != 10) bus.opcode = 3'd0;
      repeat (n) @(negedge tb_clk);
   endtask

   initial begin
      n_rst      = 1'b0;
      bus.opcode = 3'd0;
      bus.row    = '0;
      bus.col    = '0;
      bus.bank   = '0;
      repeat (3) @(negedge tb_clk);
      check("reset_vals", 32'(obs_all()), 32'(EXP_RST));
`ifdef SEQ_PROTOCOL_CHECK_EN
      check("err_reset", 32'(err), 32'd0);
`endif
      n_rst = 1'b1;
      @(negedge tb_clk);

      do_op(8, 2'd0, 13'h0, 9'h0, 5);
`ifdef SEQ_PROTOCOL_CHECK_EN
      check("err_uninit_op4", 32'(err), 32'd1);
`endif
      do_op(1, 2'd0, 13'h0000, 9'h000, 0);
      do_op(0, 2'd0, 13'h0000, 9'h000, 0);
      do_op(5, 2'd1, 13'h0155, 9'h0A0, 0);
      do_op(6, 2'd2, 13'h00AA, 9'h1F0, 0);
      do_op(7, 2'd3, 13'h1FFF, 9'h155, 0);
      do_op(3, 2'd0, 13'h0000, 9'h000, 0);
      do_op(4, 2'd0, 13'h0123, 9'h007, 0);
      do_op(2, 2'd0, 13'h0000, 9'h000, 0);
      do_op(9, 2'd0, 13'h0000, 9'h000, 0);
      do_op(5, 2'd1, 13'h0155, 9'h0A0, 7);

      #2 n_rst = 1'b0;
      #1 check("rst_async", 32'(obs_all()), 32'(EXP_RST));
`ifdef SEQ_PROTOCOL_CHECK_EN
      check("err_cleared", 32'(err), 32'd0);
`endif
      @(negedge tb_clk);
      n_rst = 1'b1;
      do_op(10, 2'd1, 13'h0155, 9'h0A0, 4);
`ifdef SEQ_PROTOCOL_CHECK_EN
      check("err_uninit_op5", 32'(err), 32'd1);
`endif

      for (int i = 0; i < 200 && sb.size() > 0; i++) @(negedge tb_clk);
      if (sb.size() != 0) check("sb_drain", 32'(sb.size()), 32'd0);

      $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
      $finish;
   end
endmodule
